// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } state_t;

  localparam int MIN_WIDTH = 4;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the issuing stage (master) and muldiv_unit (slave).
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             start;
  op_t              op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, err, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, err, hi, lo
  );

endinterface

// File: rtl/muldiv_div_core.sv
// Restoring-division step on magnitudes plus final sign fix / divide-by-zero mapping.
// Purely combinational; the iteration registers live in muldiv_unit.
module muldiv_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res,
  output logic             err_res
);

  logic [WIDTH-1:0] d_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             neg_q;
  logic             neg_r;

  always_comb begin
    d_mag   = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {1'b0, d_mag};
    // Remainder stays below the divisor, so a set top bit of diff means borrow.
    if (diff[WIDTH]) begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo_in[WIDTH-2:0], 1'b1};
    end

    neg_q = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
    neg_r = is_signed && dividend[WIDTH-1];
    if (divisor == '0) begin
      lo_res  = '1;
      hi_res  = dividend;
      err_res = 1'b1;
    end else begin
      lo_res  = neg_q ? -quo_in : quo_in;
      hi_res  = neg_r ? -rem_in : rem_in;
      err_res = 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU; WIDTH+1 cycle latency, start ignored while busy (no queue).
// Divider present only with MULDIV_DIV_EN defined; otherwise div ops complete with err=1 and zero results.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clock,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    count;
  op_t              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] lo_q;
  logic             q_1;

  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] lo_next;
  logic             q1_next;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] load_lo;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic             div_err;

  muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
    .is_signed (op_q == OP_DIV),
    .dividend  (a_q),
    .divisor   (b_q),
    .rem_in    (acc[WIDTH-1:0]),
    .quo_in    (lo_q),
    .rem_next  (rem_next),
    .quo_next  (quo_next),
    .hi_res    (div_hi),
    .lo_res    (div_lo),
    .err_res   (div_err)
  );

  // Division shifts the dividend magnitude out of lo_q; multiply keeps the multiplier there.
  always_comb begin
    load_lo = bus.operand_b;
    if (bus.op == OP_DIV)
      load_lo = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
    else if (bus.op == OP_DIVU)
      load_lo = bus.operand_a;
  end
`else
  always_comb load_lo = bus.operand_b;
`endif

  // acc carries one guard bit: Booth sign for MULT, carry-out for MULTU.
  always_comb begin
    sum      = acc;
    acc_next = acc;
    lo_next  = lo_q;
    q1_next  = q_1;
    case (op_q)
      OP_MULT: begin
        case ({lo_q[0], q_1})
          2'b01:   sum = acc + {a_q[WIDTH-1], a_q};
          2'b10:   sum = acc - {a_q[WIDTH-1], a_q};
          default: sum = acc;
        endcase
        {acc_next, lo_next} = {sum[WIDTH], sum, lo_q[WIDTH-1:1]};
        q1_next = lo_q[0];
      end
      OP_MULTU: begin
        sum = lo_q[0] ? acc + {1'b0, a_q} : acc;
        {acc_next, lo_next} = {1'b0, sum, lo_q[WIDTH-1:1]};
      end
      default: begin
`ifdef MULDIV_DIV_EN
        acc_next = {1'b0, rem_next};
        lo_next  = quo_next;
`endif
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      op_q     <= OP_MULT;
      a_q      <= '0;
      acc      <= '0;
      lo_q     <= '0;
      q_1      <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
`ifdef MULDIV_DIV_EN
      b_q      <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            a_q      <= bus.operand_a;
            acc      <= '0;
            lo_q     <= load_lo;
            q_1      <= 1'b0;
            count    <= CW'(WIDTH);
            bus.busy <= 1'b1;
            state    <= CALC;
`ifdef MULDIV_DIV_EN
            b_q      <= bus.operand_b;
`endif
          end
        end
        CALC: begin
          acc   <= acc_next;
          lo_q  <= lo_next;
          q_1   <= q1_next;
          count <= count - CW'(1);
          if (count == CW'(1))
            state <= FINISH;
        end
        FINISH: begin
          if (op_q == OP_MULT || op_q == OP_MULTU) begin
            bus.hi  <= acc[WIDTH-1:0];
            bus.lo  <= lo_q;
            bus.err <= 1'b0;
          end else begin
`ifdef MULDIV_DIV_EN
            bus.hi  <= div_hi;
            bus.lo  <= div_lo;
            bus.err <= div_err;
`else
            bus.hi  <= '0;
            bus.lo  <= '0;
            bus.err <= 1'b1;
`endif
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
